// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM access controller:
// bus widths, default depth, FSM state encoding and the zero word.
package rom_arbiter_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_DATA_BUS = 32;
    localparam int ROM_NUM_DEF   = 4096;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PROG = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/rom_prio_arb.sv
// Two-requester priority arbiter: load port wins unless fetch has already
// waited through MAX_LS_STREAK consecutive load grants.
module rom_prio_arb #(
    parameter int MAX_LS_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    logic [SW-1:0] ls_streak;
    logic          fetch_starved;

    assign fetch_starved = if_req && (ls_streak == STREAK_MAX);

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (en) begin
            if (ls_req && !fetch_starved) begin
                ls_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Streak only grows while fetch is actually waiting; a load grant with no
    // pending fetch leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_streak <= '0;
        end else if (clr || !ls_req || if_gnt) begin
            ls_streak <= '0;
        end else if (ls_gnt && if_req && (ls_streak != STREAK_MAX)) begin
            ls_streak <= ls_streak + SW'(1);
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Single-port instruction-ROM controller: arbitrates fetch/load reads and
// sequences UART programming sessions that stream words into the ROM.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W        = INST_ADDR_BUS,
    parameter int DATA_W        = INST_DATA_BUS,
    parameter int ROM_NUM       = ROM_NUM_DEF,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_W-1:0]         if_addr,
    output logic                      if_gnt,
    output logic [DATA_W-1:0]         if_data,
    input  logic                      ls_req,
    input  logic [ADDR_W-1:0]         ls_addr,
    output logic                      ls_gnt,
    output logic [DATA_W-1:0]         ls_data,
    input  logic                      prog_start,
    input  logic                      prog_valid,
    input  logic [DATA_W-1:0]         prog_data,
    input  logic                      prog_last,
    output logic                      prog_ready,
    output logic                      prog_busy,
    output logic                      prog_done,
    output logic                      prog_err,
    output logic [$clog2(ROM_NUM):0]  prog_cnt,
    output logic                      rom_wr_en,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [DATA_W-1:0]         rom_wdata,
    input  logic [DATA_W-1:0]         rom_rdata
);

    localparam int CNT_W = $clog2(ROM_NUM) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ROM_NUM);

    state_t            state;
    logic              run;
    logic              enter_prog;
    logic              accept;
    logic [ADDR_W-1:0] prog_addr;

    // Grants are masked during reset so every output reads 0 while rst is high.
    assign run        = (state == RUN) && !rst;
    assign enter_prog = (state == RUN) && prog_start;
    assign prog_ready = (state == PROG) && (prog_cnt < CNT_LIMIT);
    assign accept     = prog_ready && prog_valid;
    assign prog_addr  = ADDR_W'({prog_cnt, 2'b00});

    rom_prio_arb #(
        .MAX_LS_STREAK(MAX_LS_STREAK)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (run),
        .clr    (enter_prog),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_gnt (if_gnt),
        .ls_gnt (ls_gnt)
    );

    always_comb begin
        rom_wr_en = accept;
        rom_wdata = accept ? prog_data : DATA_W'(ZERO_WORD);
        if (accept) begin
            rom_addr = prog_addr;
        end else if (ls_gnt) begin
            rom_addr = ls_addr;
        end else if (run) begin
            rom_addr = if_addr;
        end else begin
            rom_addr = '0;
        end
    end

    assign if_data = if_gnt ? rom_rdata : DATA_W'(ZERO_WORD);
    assign ls_data = ls_gnt ? rom_rdata : DATA_W'(ZERO_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            prog_cnt  <= '0;
            prog_err  <= 1'b0;
            prog_busy <= 1'b0;
            prog_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (prog_start) begin
                        state     <= PROG;
                        prog_cnt  <= '0;
                        prog_err  <= 1'b0;
                        prog_busy <= 1'b1;
                    end
                end
                PROG: begin
                    // Words past the ROM end are dropped, but prog_last still closes the session.
                    if (prog_valid) begin
                        if (prog_cnt < CNT_LIMIT) begin
                            prog_cnt <= prog_cnt + CNT_W'(1);
                        end else begin
                            prog_err <= 1'b1;
                        end
                        if (prog_last) begin
                            state     <= DONE;
                            prog_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= RUN;
                    prog_busy <= 1'b0;
                    prog_done <= 1'b0;
                end
                default: begin
                    state     <= RUN;
                    prog_busy <= 1'b0;
                    prog_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of arbitration and programming.
module tb_rom_arbiter;

    localparam int ROM_N = 4;
    localparam int MAX_S = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(ROM_N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, ls_req, prog_start, prog_valid, prog_last;
    logic [AW-1:0] if_addr, ls_addr;
    logic [DW-1:0] prog_data;
    logic          if_gnt, ls_gnt, prog_ready, prog_busy, prog_done, prog_err;
    logic [DW-1:0] if_data, ls_data, rom_wdata, rom_rdata;
    logic [CW-1:0] prog_cnt;
    logic          rom_wr_en;
    logic [AW-1:0] rom_addr;

    always #5 clk = ~clk;

    rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ROM_NUM(ROM_N), .MAX_LS_STREAK(MAX_S)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_data(if_data),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_data(ls_data),
        .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_last(prog_last), .prog_ready(prog_ready), .prog_busy(prog_busy),
        .prog_done(prog_done), .prog_err(prog_err), .prog_cnt(prog_cnt),
        .rom_wr_en(rom_wr_en), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .rom_rdata(rom_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    // Small ROM: combinational read, write captured on the rising edge.
    logic [31:0] rom_mem [16];
    logic [15:0] wr_flag = '0;
    assign rom_rdata = wr_flag[rom_addr[5:2]] ? rom_mem[rom_addr[5:2]] : init_word(int'(rom_addr[5:2]));
    always @(posedge clk) begin
        if (rom_wr_en) begin
            rom_mem[rom_addr[5:2]] <= rom_wdata;
            wr_flag[rom_addr[5:2]] <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: mode 0=running, 1=programming, 2=session end.
    int          m_mode, m_cnt, m_streak;
    bit          m_err;
    logic [31:0] ref_rom [16];
    bit          e_if, e_ls, e_acc;

    task automatic sample_all();
        bit e_rdy;
        @(negedge clk);
        e_ls  = (m_mode == 0) && ls_req && !(if_req && m_streak == MAX_S);
        e_if  = (m_mode == 0) && if_req && !e_ls;
        e_rdy = (m_mode == 1) && (m_cnt < ROM_N);
        e_acc = e_rdy && prog_valid;
        check("if_gnt", if_gnt, e_if);
        check("ls_gnt", ls_gnt, e_ls);
        check("if_data", if_data, e_if ? ref_rom[if_addr[5:2]] : 32'h0);
        check("ls_data", ls_data, e_ls ? ref_rom[ls_addr[5:2]] : 32'h0);
        check("prog_ready", prog_ready, e_rdy);
        check("prog_busy", prog_busy, m_mode != 0);
        check("prog_done", prog_done, m_mode == 2);
        check("prog_err", prog_err, m_err);
        check("prog_cnt", prog_cnt, m_cnt);
        check("rom_wr_en", rom_wr_en, e_acc);
        check("rom_wdata", rom_wdata, e_acc ? prog_data : 32'h0);
        if (e_acc)
            check("rom_addr_wr", rom_addr, m_cnt * 4);
        else if (e_ls)
            check("rom_addr_ls", rom_addr, ls_addr);
        else if (e_if)
            check("rom_addr_if", rom_addr, if_addr);
    endtask

    task automatic advance();
        if (m_mode == 0 && prog_start) m_streak = 0;
        else if (!ls_req || e_if)      m_streak = 0;
        else if (e_ls && if_req && m_streak < MAX_S) m_streak++;
        case (m_mode)
            0: if (prog_start) begin m_mode = 1; m_cnt = 0; m_err = 0; end
            1: if (prog_valid) begin
                if (m_cnt < ROM_N) begin
                    ref_rom[m_cnt] = prog_data;
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
                if (prog_last) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample_all();
        advance();
    endtask

    task automatic idle();
        if_req = 0; ls_req = 0; prog_start = 0; prog_valid = 0; prog_last = 0;
        if_addr = '0; ls_addr = '0; prog_data = '0;
    endtask

    // Reset pulse with live requests: every output must still read 0.
    task automatic reset_pulse(input string tag);
        rst = 1;
        @(negedge clk);
        check({tag, "_if_gnt"}, if_gnt, 0);
        check({tag, "_ls_gnt"}, ls_gnt, 0);
        check({tag, "_if_data"}, if_data, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_wr_en"}, rom_wr_en, 0);
        check({tag, "_busy"}, prog_busy, 0);
        check({tag, "_done"}, prog_done, 0);
        check({tag, "_err"}, prog_err, 0);
        check({tag, "_cnt"}, prog_cnt, 0);
        check({tag, "_ready"}, prog_ready, 0);
        m_mode = 0; m_cnt = 0; m_err = 0; m_streak = 0;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_rom[i] = init_word(i);
        m_mode = 0; m_cnt = 0; m_err = 0; m_streak = 0;
        idle();
        rst = 1;
        if_req = 1; if_addr = 32'h8; ls_req = 1; ls_addr = 32'h4; prog_valid = 1;
        @(posedge clk);
        #1;
        reset_pulse("por");

        // Fetch only
        idle();
        if_req = 1; if_addr = 32'h8;
        sample_all();
        check("fetch_gnt", if_gnt, 1);
        check("fetch_addr", rom_addr, 32'h8);
        check("fetch_data", if_data, init_word(2));
        advance();

        // Contention: 4 loads then 1 fetch, repeating
        idle();
        if_req = 1; ls_req = 1;
        for (int i = 0; i < 10; i++) begin
            if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            ls_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            sample_all();
            check("cont_ls", ls_gnt, (i % 5) != 4);
            check("cont_if", if_gnt, (i % 5) == 4);
            advance();
        end

        // Three-word session 0xA, 0xB, 0xC
        idle();
        if_req = 1; if_addr = 32'h4; prog_start = 1;
        sample_all();
        check("sess_inflight", if_gnt, 1);
        advance();
        prog_start = 0;
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1; prog_data = 32'hA + 32'(i); prog_last = (i == 2);
            sample_all();
            check("sess_wr", rom_wr_en, 1);
            check("sess_addr", rom_addr, i * 4);
            check("sess_if", if_gnt, 0);
            advance();
        end
        prog_valid = 0; prog_last = 0; if_addr = 32'h8;
        sample_all();
        check("sess_done", prog_done, 1);
        check("sess_cnt", prog_cnt, 3);
        check("sess_if_done", if_gnt, 0);
        advance();
        sample_all();
        check("sess_resume", if_gnt, 1);
        check("sess_rd", if_data, 32'hC);
        advance();

        // Overflow: six words into a four-word ROM
        idle();
        prog_start = 1;
        cyc();
        prog_start = 0;
        for (int i = 0; i < 6; i++) begin
            prog_valid = 1; prog_data = 32'h100 + 32'(i); prog_last = (i == 5);
            sample_all();
            check("ovf_wr", rom_wr_en, i < 4);
            if (i == 5) check("ovf_err", prog_err, 1);
            advance();
        end
        idle();
        sample_all();
        check("ovf_done", prog_done, 1);
        check("ovf_cnt", prog_cnt, 4);
        advance();
        prog_start = 1;
        sample_all();
        check("ovf_sticky", prog_err, 1);
        advance();
        prog_start = 0;
        sample_all();
        check("ovf_clr", prog_err, 0);
        advance();
        prog_valid = 1; prog_last = 1; prog_data = 32'h55;
        cyc();
        idle();
        cyc();
        cyc();

        // Reset in the middle of a session
        prog_start = 1;
        cyc();
        prog_start = 0;
        for (int i = 0; i < 2; i++) begin
            prog_valid = 1; prog_data = 32'h200 + 32'(i);
            cyc();
        end
        if_req = 1; if_addr = 32'h4; prog_valid = 1;
        reset_pulse("rst_mid");
        idle();
        if_req = 1; if_addr = 32'h0;
        sample_all();
        check("rst_resume", if_gnt, 1);
        check("rst_keep", if_data, 32'h200);
        advance();

        // prog_start ignored inside a session; gaps do not advance the count
        idle();
        prog_start = 1;
        cyc();
        prog_valid = 0;
        cyc();
        prog_start = 0; prog_valid = 1; prog_data = 32'h300;
        cyc();
        prog_valid = 0;
        cyc();
        prog_start = 1; prog_valid = 1; prog_data = 32'h301;
        cyc();
        prog_start = 0; prog_valid = 0;
        sample_all();
        check("ign_cnt", prog_cnt, 2);
        check("ign_busy", prog_busy, 1);
        advance();
        prog_valid = 1; prog_last = 1; prog_data = 32'h302;
        cyc();
        idle();
        cyc();
        cyc();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if_req     = ($urandom_range(0, 3) != 0);
            ls_req     = ($urandom_range(0, 2) != 0);
            if_addr    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            ls_addr    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            prog_start = ($urandom_range(0, 39) == 0);
            prog_valid = ($urandom_range(0, 1) == 1);
            prog_last  = ($urandom_range(0, 5) == 0);
            prog_data  = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Single-port access controller for the instruction ROM. It shares the ROM between the core's instruction-fetch port, a read-only load port from the load/store stage and a programming port driven by the UART debug loader. It also sequences a programming session, holding the core while words are streamed into the ROM.

## Interface

Parameters:
- `ADDR_W`, 32, byte-address width of all address ports.
- `DATA_W`, 32, ROM word width.
- `ROM_NUM`, 4096, ROM depth in words; must match the ROM instance.
- `MAX_LS_STREAK`, 4, maximum consecutive load grants while a fetch is waiting.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch served this cycle; when 0 the pipeline stalls fetch.
- `if_data`  out  DATA_W  fetch data; valid when `if_gnt`=1, else 0.
- `ls_req`  in  1  load-port read request.
- `ls_addr`  in  ADDR_W  load byte address.
- `ls_gnt`  out  1  load served this cycle.
- `ls_data`  out  DATA_W  load data; valid when `ls_gnt`=1, else 0.
- `prog_start`  in  1  single-cycle pulse that opens a programming session.
- `prog_valid`  in  1  programming word valid.
- `prog_data`  in  DATA_W  programming word.
- `prog_last`  in  1  qualifies the final word of a session.
- `prog_ready`  out  1  word accepted when `prog_valid` and `prog_ready` are both 1.
- `prog_busy`  out  1  a session is active; the core must hold.
- `prog_done`  out  1  single-cycle pulse at session end; the core resets its PC.
- `prog_err`  out  1  sticky overflow flag; cleared by the next `prog_start`.
- `prog_cnt`  out  clog2(ROM_NUM)+1  words written in the current session.
- `rom_wr_en`  out  1  ROM write enable.
- `rom_addr`  out  ADDR_W  ROM byte address.
- `rom_wdata`  out  DATA_W  ROM write data.
- `rom_rdata`  in  DATA_W  ROM combinational read data.

## Operation

State machine with three states: RUN, PROG, DONE. Reset state is RUN.

RUN state:
- Read accesses are combinational through the ROM.
- `rom_addr` is `ls_addr` when `ls_gnt`=1, otherwise `if_addr`.
- If only one of `if_req` / `ls_req` is high, that requester is granted.
- If both are high, load wins, except when `ls_streak`==MAX_LS_STREAK. In that case fetch is granted.
- `ls_streak` behaviour:
  - increments on each load grant while `if_req`=1;
  - clears on any fetch grant, and whenever `ls_req`=0;
  - saturates at MAX_LS_STREAK.
- `prog_start`=1 moves to PROG on the next edge. Any in-flight read in that cycle is still granted.

PROG state:
- `if_gnt` and `ls_gnt` are 0; `prog_busy`=1.
- `prog_ready` is 1 while `prog_cnt` < ROM_NUM.
- An accepted word drives `rom_wr_en`=1, `rom_addr`={`prog_cnt`,2'b00} and `rom_wdata`=`prog_data` in the same cycle. `prog_cnt` increments on that edge.
- If `prog_valid`=1 while `prog_cnt`==ROM_NUM:
  - the word is dropped and `prog_err` is set;
  - `prog_ready` stays 0;
  - the session ends only when a word arrives with `prog_last`=1; that word is also dropped and the state moves to DONE.
- An accepted word with `prog_last`=1 moves the state to DONE.
- `prog_start` is ignored while in PROG.

DONE state:
- Lasts exactly one cycle; `prog_busy`=1 and `prog_done`=1.
- Returns to RUN.
- `prog_cnt` holds its value until the next `prog_start`.

Entering PROG clears `prog_cnt`, `prog_err` and `ls_streak`.

Reset mid-session returns to RUN with all counters cleared. A partially written ROM is left as-is.

## Timing

- All outputs reset to 0.
- Read latency: 0 cycles. Grant and data appear in the same cycle as the request.
- Write: one word per cycle at most. The ROM captures it on the rising edge that ends the accept cycle.
- `prog_start` in cycle N gives `prog_busy`=1 and `prog_ready`=1 from cycle N+1.
- Last word accepted in cycle M gives `prog_done`=1 in cycle M+1 and the RUN state with grants in cycle M+2.
- `prog_busy` and `prog_done` are registered (decoded from the state register). Grants, `prog_ready`, `rom_*` and read data are combinational from state and inputs.
- If `if_req` and `ls_req` are both held high, the steady-state grant pattern is MAX_LS_STREAK load grants, then 1 fetch grant, repeating.

## Structure

- Shared package/defines: ADDR_W/DATA_W (existing INST_ADDR_BUS / INST_DATA_BUS), ROM_NUM, the state encodings (RUN=2'd0, PROG=2'd1, DONE=2'd2) and the ZERO_WORD constant.
- One sub-module, `rom_prio_arb`: two-requester priority arbiter with the streak counter.
- Programming FSM, write counter and address mux stay in the top level.

## Test plan

- Fetch only: `if_req`=1, `if_addr`=0x8 → `if_gnt`=1, `rom_addr`=0x8 and `if_data`=`rom_rdata` in the same cycle.
- Contention, MAX_LS_STREAK=4: both requests held for 10 cycles → `ls_gnt` in cycles 0-3 and 5-8, `if_gnt` in cycles 4 and 9.
- Session of 3 words 0xA,0xB,0xC, with `prog_last` on 0xC → writes at 0x0,0x4,0x8; `prog_cnt`=3; `prog_done` pulses the cycle after 0xC; `if_gnt` is 0 throughout and returns 2 cycles after 0xC.
- Overflow, ROM_NUM=4: 6 words streamed → only the first 4 are written; `prog_err`=1 after word 5; DONE follows the `prog_last` word; the next `prog_start` clears `prog_err`.
- `rst` pulse in PROG after 2 words → state returns to RUN immediately, all outputs read 0, then fetch resumes.
- `prog_start` while in PROG and while `prog_valid` gaps occur → the start is ignored; `prog_cnt` advances only on accepted words.
